in_channel_arbiter: RTL and testbench
=====================================

# in_channel_arbiter

- Packet-granular round-robin arbiter that merges four per-channel Avalon-ST ingress streams into the single ingress stream of the inbound node-FIFO chain.
- Drives `st_data/st_sop/st_eop/st_valid/st_channel` and honours `st_ready` and the chain's `xoff`.
- Never interleaves packets. Starts no new packet while `xoff` is high. Counts forwarded packets per channel.

## Interface

Parameters:
- `NREQ`, 4: number of requesters. Fixed at 4 to match the 2-bit `st_channel`.
- `DATA_W`, 148: beat width, equal to the chain's `st_data` width.
- `CNT_W`, 16: width of the per-channel packet counters.

Ports:
- `clock` in 1: single clock; all logic is on its rising edge.
- `sclr_n` in 1: synchronous, active-low reset.
- `in_data[NREQ]` in DATA_W: requester beat data.
- `in_sop[NREQ]`, `in_eop[NREQ]`, `in_valid[NREQ]` in 1 each: requester framing and valid.
- `in_ready[NREQ]` out 1 each: beat accepted when `in_valid && in_ready`.
- `st_data` out DATA_W; `st_sop`, `st_eop`, `st_valid` out 1 each; `st_channel` out 2: to the chain.
- `st_ready` in 1: chain ready.
- `xoff` in 1: chain almost-full; blocks new packet starts.
- `grant` out NREQ: one-hot owner of the packet in flight; all-zero in IDLE.
- `pkt_count[NREQ]` out CNT_W: packets forwarded per channel, wrapping.
- `proto_err` out 1: sticky; set when an orphan beat is drained.

## Operation

- State machine with two states:
  - **IDLE:** no packet owner.
  - **LOCK(g):** requester g owns the output.
- IDLE → LOCK(g) when `xoff==0` and at least one requester has `in_valid && in_sop`.
  - g is the first such requester in order `last+1, last+2, …` modulo NREQ.
  - `last` holds the previous winner.
- IDLE holds while `xoff==1`, regardless of requests.
- Orphan beats in IDLE: any requester presenting `in_valid && !in_sop` gets `in_ready=1` that cycle.
  - The beat is discarded and `proto_err` is set.
  - The orphan requester is not eligible for grant that cycle.
- In LOCK(g):
  - `in_ready[g] = !st_valid || st_ready`; all other `in_ready` are 0.
  - An accepted beat loads the output register: data, sop, eop, valid=1, `st_channel=g`.
  - An accepted beat with `in_eop` moves to IDLE, sets `last=g` and increments `pkt_count[g]`.
- `xoff` is ignored in LOCK; a packet in progress always completes.
- A `in_sop` seen mid-packet in LOCK is forwarded unchanged and does not change state.
- A single-beat packet (`sop && eop`) locks for exactly one accepted beat.
- Output register:
  - `st_valid` clears when `st_ready && st_valid` and no new beat loads that cycle.
  - Load and drain in the same cycle keeps `st_valid=1` with the new beat.
  - Contents hold stable while `st_valid && !st_ready`.
- `pkt_count` wraps from 2^CNT_W−1 to 0.
- `proto_err` clears only on reset.

## Timing

- Reset (`sclr_n==0` at a clock edge) sets:
  - state IDLE, `last=NREQ-1` (so requester 0 has first priority);
  - `st_valid=0`, `st_sop=0`, `st_eop=0`, `st_channel=0`, `st_data=0`;
  - `grant=0`, all `pkt_count=0`, `proto_err=0`.
- During reset, all `in_ready=0`.
- Reset mid-packet abandons the packet: no eop is emitted and the downstream chain is reset together with this block.
- Latency: accepted input beat appears on `st_*` the next cycle.
- Arbitration costs one cycle per packet: the IDLE decision cycle carries no data beat.
- `in_ready` is combinational from state, `st_valid` and `st_ready`. It does not depend on `in_valid`.
- `grant` is registered and equals the LOCK owner.
- `xoff` takes effect at the next IDLE decision; it is sampled the same cycle.

## Structure

- Shared package `in_arb_pkg`:
  - `NREQ`, `DATA_W`, `CNT_W` constants;
  - state enum `{ARB_IDLE, ARB_LOCK}`;
  - `beat_t` struct `{data, sop, eop}`.
- One sub-module, `rr_pick`: combinational round-robin first-one search.
  - Inputs: `req[NREQ]`, `last`.
  - Outputs: `found`, `idx`.
- Output register, FSM and counters live in `in_channel_arbiter`.

## Test plan

- **Simple forward:** after reset, requester 2 sends 3-beat packet A0..A2, `st_ready=1`.
  - IDLE cycle, then `st_channel=2` beats A0(sop), A1, A2(eop) on consecutive cycles.
  - `pkt_count[2]=1`, `grant=0100` during the packet.
- **Round-robin fairness:** all four requesters hold continuous 2-beat packets.
  - Output channel order 0,1,2,3,0,1… with no interleaving inside a packet.
  - After 8 packets, every `pkt_count=2`.
- **xoff:**
  - `xoff` rises on the second beat of a 4-beat packet from requester 1: that packet completes, then no new sop appears while `xoff=1`.
  - `xoff` falls: the next packet starts one cycle later.
- **Backpressure:** `st_ready` toggles 1,0,0,1 during a packet.
  - `st_*` holds stable while stalled, no beat is lost or duplicated, and `in_ready` mirrors `!st_valid || st_ready`.
- **Orphan and single-beat:**
  - Requester 3 sends a beat without sop in IDLE: it is drained, `proto_err=1`, nothing appears on `st_valid`.
  - Requester 3 then sends a sop+eop beat: forwarded, `pkt_count[3]=1`.
- **Reset mid-packet and counter wrap:**
  - Assert `sclr_n=0` during beat 2 of a packet: next cycle `st_valid=0`, `grant=0`, counters 0.
  - With CNT_W=4, 17 packets from requester 0 give `pkt_count[0]=1`.

Source files
------------

// File: rtl/in_arb_pkg.sv
// Shared constants and types for the inbound channel arbiter: sizes, FSM state
// encoding, the beat record carried through the output register and a one-hot helper.
package in_arb_pkg;

    localparam int NREQ   = 4;
    localparam int DATA_W = 148;
    localparam int CNT_W  = 16;
    localparam int IDX_W  = 2;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } beat_t;

    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        idx_to_onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/in_channel_arbiter_rr_pick.sv
// Combinational round-robin search: first requester after 'last', wrapping
// modulo NREQ, with 'last' itself as the lowest priority.
module rr_pick
    import in_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand_s;

    // Walk from lowest to highest priority so the nearest requester after 'last' wins.
    always_comb begin
        found  = 1'b0;
        idx    = {IDX_W{1'b0}};
        cand_s = {IDX_W{1'b0}};
        for (int k = NREQ; k >= 1; k--) begin
            cand_s = IDX_W'((int'(last) + k) % NREQ);
            if (req[cand_s]) begin
                found = 1'b1;
                idx   = cand_s;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/in_channel_arbiter.sv
// Packet-granular round-robin merge of four Avalon-ST requesters into the inbound
// node-FIFO chain, with a registered output stage and per-channel packet counters.
module in_channel_arbiter #(
    parameter int NREQ   = in_arb_pkg::NREQ,
    parameter int DATA_W = in_arb_pkg::DATA_W,
    parameter int CNT_W  = in_arb_pkg::CNT_W
) (
    input  logic              clock,
    input  logic              sclr_n,
    input  logic [DATA_W-1:0] in_data [NREQ],
    input  logic [NREQ-1:0]   in_sop,
    input  logic [NREQ-1:0]   in_eop,
    input  logic [NREQ-1:0]   in_valid,
    output logic [NREQ-1:0]   in_ready,
    output logic [DATA_W-1:0] st_data,
    output logic              st_sop,
    output logic              st_eop,
    output logic              st_valid,
    output logic [1:0]        st_channel,
    input  logic              st_ready,
    input  logic              xoff,
    output logic [NREQ-1:0]   grant,
    output logic [CNT_W-1:0]  pkt_count [NREQ],
    output logic              proto_err
);

    import in_arb_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    arb_state_t       state_r,     state_nxt_s;
    logic [IDX_W-1:0] owner_r,     owner_nxt_s;
    logic [IDX_W-1:0] last_r,      last_nxt_s;
    logic [NREQ-1:0]  grant_r,     grant_nxt_s;
    beat_t            out_beat_r,  out_beat_nxt_s;
    logic             out_valid_r, out_valid_nxt_s;
    logic [1:0]       out_chan_r,  out_chan_nxt_s;
    logic             proto_err_r, proto_err_nxt_s;
    logic [CNT_W-1:0] cnt_r [NREQ];

    logic [NREQ-1:0]  req_s;
    logic             found_s;
    logic [IDX_W-1:0] pick_s;
    logic             out_free_s;
    logic             accept_s;
    logic             orphan_s;
    logic             cnt_inc_s;
    beat_t            sel_beat_s;

    // Only sop-carrying beats compete, so an orphan is never eligible in its own cycle.
    assign req_s      = in_valid & in_sop;
    assign sel_beat_s = {in_data[owner_r], in_sop[owner_r], in_eop[owner_r]};

    rr_pick u_rr_pick (
        .req   (req_s),
        .last  (last_r),
        .found (found_s),
        .idx   (pick_s)
    );

    // Ready generation, acceptance and orphan detection.
    always_comb begin
        out_free_s = !out_valid_r || st_ready;
        in_ready   = {NREQ{1'b0}};
        if (!sclr_n) begin
            in_ready = {NREQ{1'b0}};
        end else begin
            case (state_r)
                ARB_IDLE: in_ready = ~in_sop;
                ARB_LOCK: in_ready = idx_to_onehot(owner_r) & {NREQ{out_free_s}};
                default:  in_ready = {NREQ{1'b0}};
            endcase
        end
        accept_s = (state_r == ARB_LOCK) && in_valid[owner_r] && out_free_s;
        orphan_s = (state_r == ARB_IDLE) && (|(in_valid & ~in_sop));
    end

    // Next-state, output-register and bookkeeping decisions.
    always_comb begin
        state_nxt_s     = state_r;
        owner_nxt_s     = owner_r;
        last_nxt_s      = last_r;
        grant_nxt_s     = grant_r;
        out_beat_nxt_s  = out_beat_r;
        out_chan_nxt_s  = out_chan_r;
        out_valid_nxt_s = out_valid_r && !st_ready;
        proto_err_nxt_s = proto_err_r | orphan_s;
        cnt_inc_s       = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (!xoff && found_s) begin
                    state_nxt_s = ARB_LOCK;
                    owner_nxt_s = pick_s;
                    grant_nxt_s = idx_to_onehot(pick_s);
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_LOCK: begin
                if (accept_s) begin
                    out_beat_nxt_s  = sel_beat_s;
                    out_valid_nxt_s = 1'b1;
                    out_chan_nxt_s  = owner_r;
                    if (sel_beat_s.eop) begin
                        state_nxt_s = ARB_IDLE;
                        last_nxt_s  = owner_r;
                        grant_nxt_s = {NREQ{1'b0}};
                        cnt_inc_s   = 1'b1;
                    end else begin
                        state_nxt_s = ARB_LOCK;
                    end
                end else begin
                    state_nxt_s = ARB_LOCK;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
                grant_nxt_s = {NREQ{1'b0}};
            end
        endcase
    end

    // FSM, output register and sticky error flag.
    always_ff @(posedge clock) begin
        if (!sclr_n) begin
            state_r     <= ARB_IDLE;
            owner_r     <= {IDX_W{1'b0}};
            last_r      <= {IDX_W{1'b1}};
            grant_r     <= {NREQ{1'b0}};
            out_beat_r  <= '{data: {DATA_W{1'b0}}, sop: 1'b0, eop: 1'b0};
            out_valid_r <= 1'b0;
            out_chan_r  <= 2'd0;
            proto_err_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            owner_r     <= owner_nxt_s;
            last_r      <= last_nxt_s;
            grant_r     <= grant_nxt_s;
            out_beat_r  <= out_beat_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_chan_r  <= out_chan_nxt_s;
            proto_err_r <= proto_err_nxt_s;
        end
    end

    // Per-channel packet counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NREQ; i++) begin
            if (!sclr_n) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end else if (cnt_inc_s && (owner_r == IDX_W'(i))) begin
                cnt_r[i] <= cnt_r[i] + CNT_ONE;
            end else begin
                cnt_r[i] <= cnt_r[i];
            end
        end
    end

    assign st_data    = out_beat_r.data;
    assign st_sop     = out_beat_r.sop;
    assign st_eop     = out_beat_r.eop;
    assign st_valid   = out_valid_r;
    assign st_channel = out_chan_r;
    assign grant      = grant_r;
    assign pkt_count  = cnt_r;
    assign proto_err  = proto_err_r;

endmodule

// File: tb/tb_in_channel_arbiter.sv
// Scoreboard bench for in_channel_arbiter: per-channel expected beat queues fed by
// the stimulus, a monitor that pops on every output handshake, and directed timing checks.
module tb_in_channel_arbiter;

    localparam int NREQ   = 4;
    localparam int DATA_W = 148;
    localparam int CNT_W  = 4;

    logic              clock = 1'b0;
    logic              sclr_n = 1'b0;
    logic [DATA_W-1:0] in_data [NREQ];
    logic [NREQ-1:0]   in_sop = '0, in_eop = '0, in_valid = '0, in_ready;
    logic [DATA_W-1:0] st_data;
    logic              st_sop, st_eop, st_valid;
    logic [1:0]        st_channel;
    logic              st_ready = 1'b1, xoff = 1'b0;
    logic [NREQ-1:0]   grant;
    logic [CNT_W-1:0]  pkt_count [NREQ];
    logic              proto_err;

    in_channel_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .sclr_n(sclr_n), .in_data(in_data), .in_sop(in_sop),
        .in_eop(in_eop), .in_valid(in_valid), .in_ready(in_ready), .st_data(st_data),
        .st_sop(st_sop), .st_eop(st_eop), .st_valid(st_valid), .st_channel(st_channel),
        .st_ready(st_ready), .xoff(xoff), .grant(grant), .pkt_count(pkt_count),
        .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } tb_beat_t;

    tb_beat_t tx_q  [NREQ][$];
    tb_beat_t exp_q [NREQ][$];
    int       order_q[$];
    int       exp_cnt [NREQ];
    logic     exp_perr = 1'b0;
    int       n_cmp = 0, n_err = 0;
    int       rdy_mode = 0;
    bit       rand_valid = 1'b0;
    bit       chk_ir = 1'b0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_pkt(input int ch, input int len, input bit midsop);
        tb_beat_t    b;
        logic [159:0] r;
        for (int i = 0; i < len; i++) begin
            r      = {$urandom, $urandom, $urandom, $urandom, $urandom};
            b.data = r[DATA_W-1:0];
            b.sop  = (i == 0) || (midsop && (i == len / 2));
            b.eop  = (i == len - 1);
            tx_q[ch].push_back(b);
            exp_q[ch].push_back(b);
        end
        exp_cnt[ch] = (exp_cnt[ch] + 1) % (1 << CNT_W);
    endtask

    task automatic check_quiet(input string tag);
        for (int c = 0; c < NREQ; c++)
            check($sformatf("%s_pkt_count%0d", tag, c), pkt_count[c], exp_cnt[c]);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_proto_err"}, proto_err, exp_perr);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        int pend;
        bit done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clock);
            #1;
            pend = 0;
            for (int c = 0; c < NREQ; c++) pend += tx_q[c].size() + exp_q[c].size();
            done = (pend == 0) && !st_valid;
            n++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_%s: traffic still pending after %0d cycles", tag, budget);
        end
    endtask

    task automatic wait_second_beat(input int ch, input string tag);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < 100) begin
            @(negedge clock);
            hit = in_valid[ch] && in_ready[ch] && !in_sop[ch];
            n++;
        end
        if (!hit) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: second beat never accepted", tag);
        end
    endtask

    task automatic apply_reset();
        @(posedge clock);
        #2;
        sclr_n = 1'b0;
        for (int c = 0; c < NREQ; c++) begin
            tx_q[c].delete();
            exp_q[c].delete();
            exp_cnt[c] = 0;
        end
        order_q.delete();
        exp_perr = 1'b0;
        @(negedge clock);
        check("ready_in_reset", in_ready, 0);
        @(negedge clock);
        check("rst_st_valid", st_valid, 0);
        check("rst_st_sop_eop", {st_sop, st_eop}, 0);
        check("rst_st_channel", st_channel, 0);
        check("rst_st_data", st_data, 0);
        check_quiet("rst");
        @(posedge clock);
        #2;
        sclr_n = 1'b1;
        @(negedge clock);
    endtask

    // Requester and sink driver: pops beats on handshake, presents queue heads.
    initial begin
        logic [NREQ-1:0] acc;
        int pat_i = 0;
        for (int c = 0; c < NREQ; c++) in_data[c] = '0;
        forever begin
            @(posedge clock);
            acc = in_valid & in_ready;
            #1;
            for (int c = 0; c < NREQ; c++) begin
                if (acc[c] && tx_q[c].size() > 0) void'(tx_q[c].pop_front());
                if (tx_q[c].size() > 0 && (!rand_valid || $urandom_range(3) != 0)) begin
                    in_valid[c] = 1'b1;
                    in_data[c]  = tx_q[c][0].data;
                    in_sop[c]   = tx_q[c][0].sop;
                    in_eop[c]   = tx_q[c][0].eop;
                end else begin
                    in_valid[c] = 1'b0;
                    in_sop[c]   = 1'b0;
                    in_eop[c]   = 1'b0;
                end
            end
            case (rdy_mode)
                1:       st_ready = 1'($urandom_range(1));
                2:       begin st_ready = (pat_i % 4 == 0) || (pat_i % 4 == 3); pat_i++; end
                default: st_ready = 1'b1;
            endcase
        end
    end

    // Output monitor: scoreboard pops, interleave, order and stall-stability checks.
    initial begin
        bit                in_pkt = 1'b0, prev_stall = 1'b0;
        int                cur_ch = 0, ch;
        logic [DATA_W+4:0] prev_out;
        tb_beat_t          e;
        forever begin
            @(negedge clock);
            if (!sclr_n) begin
                in_pkt     = 1'b0;
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall)
                check("stall_stable", {st_valid, st_sop, st_eop, st_channel, st_data}, prev_out);
            if (chk_ir && grant != 0) begin
                check("in_ready_mirror", in_ready, (!st_valid || st_ready) ? grant : 4'b0000);
                check("bp_grant", grant, 4'b0010);
            end
            if (st_valid && st_ready) begin
                ch = int'(st_channel);
                if (in_pkt) check("no_interleave", ch, cur_ch);
                if (st_sop && !in_pkt && order_q.size() > 0)
                    check("rr_order", ch, order_q.pop_front());
                if (exp_q[ch].size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got beat on channel %0d, required none", ch);
                end else begin
                    e = exp_q[ch].pop_front();
                    check("beat", {st_sop, st_eop, st_data}, {e.sop, e.eop, e.data});
                end
                if (st_sop && !in_pkt) begin
                    in_pkt = 1'b1;
                    cur_ch = ch;
                end
                if (st_eop) in_pkt = 1'b0;
            end
            prev_stall = st_valid && !st_ready;
            prev_out   = {st_valid, st_sop, st_eop, st_channel, st_data};
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        tb_beat_t a [3];
        int       seen;
        for (int c = 0; c < NREQ; c++) exp_cnt[c] = 0;
        apply_reset();

        // Simple forward: one arbitration cycle, then three back-to-back beats.
        send_pkt(2, 3, 1'b0);
        for (int i = 0; i < 3; i++) a[i] = exp_q[2][i];
        @(negedge clock);
        check("fwd_idle_valid", st_valid, 0);
        @(negedge clock);
        check("fwd_arb_valid", st_valid, 0);
        check("fwd_grant", grant, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("fwd_beat%0d", i), {st_valid, st_sop, st_eop, st_channel, st_data},
                  {1'b1, a[i].sop, a[i].eop, 2'd2, a[i].data});
        end
        check("fwd_grant_released", grant, 0);
        check("fwd_count2", pkt_count[2], 1);
        wait_drain("fwd", 50);

        // Round-robin fairness from a fresh reset.
        apply_reset();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NREQ; c++) begin
                send_pkt(c, 2, 1'b0);
                order_q.push_back(c);
            end
        wait_drain("rr", 200);
        check("rr_order_consumed", order_q.size(), 0);
        check_quiet("rr");

        // xoff raised mid-packet: packet completes, no new start until release.
        send_pkt(1, 4, 1'b0);
        wait_second_beat(1, "xoff_wait");
        xoff = 1'b1;
        send_pkt(3, 2, 1'b0);
        seen = 0;
        repeat (12) begin
            @(negedge clock);
            if (st_valid && st_sop) seen++;
        end
        check("xoff_no_start", seen, 0);
        check("xoff_pkt_completed", pkt_count[1], exp_cnt[1]);
        xoff = 1'b0;
        @(negedge clock);
        check("xoff_rel_arb_valid", st_valid, 0);
        check("xoff_rel_grant", grant, 4'b1000);
        @(negedge clock);
        check("xoff_rel_start", {st_valid, st_sop, st_channel}, {1'b1, 1'b1, 2'd3});
        wait_drain("xoff", 100);
        check_quiet("xoff");

        // Backpressure pattern 1,0,0,1 during a six-beat packet.
        rdy_mode = 2;
        chk_ir   = 1'b1;
        send_pkt(1, 6, 1'b0);
        wait_drain("bp", 200);
        chk_ir   = 1'b0;
        rdy_mode = 0;
        check_quiet("bp");

        // Orphan drained in IDLE, then a single-beat packet.
        begin
            tb_beat_t o;
            o.data = {DATA_W{1'b1}};
            o.sop  = 1'b0;
            o.eop  = 1'b0;
            tx_q[3].push_back(o);
            exp_perr = 1'b1;
        end
        seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (st_valid) seen++;
        end
        check("orphan_no_output", seen, 0);
        check("orphan_drained", tx_q[3].size(), 0);
        check("orphan_proto_err", proto_err, 1);
        send_pkt(3, 1, 1'b0);
        wait_drain("single", 50);
        check_quiet("single");

        // Randomized traffic with random valid gaps and sink stalls.
        rdy_mode   = 1;
        rand_valid = 1'b1;
        for (int p = 0; p < 150; p++) begin
            send_pkt($urandom_range(NREQ - 1), $urandom_range(5, 1), $urandom_range(7) == 0);
            repeat ($urandom_range(3)) @(negedge clock);
        end
        wait_drain("rand", 20000);
        rdy_mode   = 0;
        rand_valid = 1'b0;
        check_quiet("rand");

        // Reset during the second beat of a packet.
        send_pkt(0, 5, 1'b0);
        wait_second_beat(0, "rst_mid_wait");
        apply_reset();

        // Counter wrap: seventeen packets on requester 0.
        for (int p = 0; p < 17; p++) send_pkt(0, 1 + (p % 2), 1'b0);
        wait_drain("wrap", 500);
        check_quiet("wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
